fp_round_arbiter: RTL and testbench

Shares one round-to-nearest-even unit between two requesters: port 0 (FP adder normalize stage) and port 1 (FP multiplier normalize stage).
- Round-robin arbitration selects one requester per cycle.
- The winning operand is registered, rounded, carry/exponent-adjusted and packed into an IEEE-754 single.
- Result is presented on a valid/ready output port.
- Two-stage pipeline with full backpressure; sits between the normalize stages and the FP register-file writeback.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_round_arbiter_rounding.sv | 25 ++
 rtl/fp_round_arbiter.sv | 136 +++++++++++++
 tb/tb_fp_round_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field widths and the operand/result
// containers used by the shared rounding stage.
package fp_pkg;

    localparam int SIG_BITS = 23;
    localparam int EXP_BITS = 8;
    localparam int MANT_W   = SIG_BITS + 4;
    localparam logic [EXP_BITS-1:0] EXP_MAX = EXP_BITS'(2**EXP_BITS - 1);

    localparam logic SRC_ADD = 1'b0;
    localparam logic SRC_MUL = 1'b1;

    typedef struct packed {
        logic                sign;
        logic [EXP_BITS-1:0] exp;
        logic [SIG_BITS-1:0] frac;
    } fp_word_t;

    // sig is {hidden, fraction, G, R, S}
    typedef struct packed {
        logic                sign;
        logic [EXP_BITS-1:0] exp;
        logic [MANT_W-1:0]   sig;
    } rnd_req_t;

endpackage

// File: rtl/fp_round_arbiter_rounding.sv
// Combinational round-to-nearest-even on {hidden, fraction, G, R, S}.
// On carry-out the rounded significand is already shifted right by one.
module rounding
    import fp_pkg::*;
(
    input  logic [MANT_W-1:0] i_sig,
    output logic [MANT_W-1:0] o_sig_r,
    output logic              o_co
);

    logic [SIG_BITS:0]   w_keep;
    logic                w_tie_even;
    logic                w_inc;
    logic [SIG_BITS+1:0] w_sum;

    assign w_keep     = i_sig[MANT_W-1:3];
    // Exact halfway with an even kept lsb stays put; otherwise G decides.
    assign w_tie_even = i_sig[2] && !i_sig[1] && !i_sig[0] && !i_sig[3];
    assign w_inc      = i_sig[2] && !w_tie_even;
    assign w_sum      = {1'b0, w_keep} + {{(SIG_BITS+1){1'b0}}, w_inc};
    assign o_co       = w_sum[SIG_BITS+1];
    assign o_sig_r    = o_co ? {w_sum[SIG_BITS+1:1], 3'b000}
                             : {w_sum[SIG_BITS:0], 3'b000};

endmodule

// File: rtl/fp_round_arbiter.sv
// Round-robin shares one RNE rounding unit between the adder and multiplier
// normalize stages; two-stage pipeline with full valid/ready backpressure.
module fp_round_arbiter
    import fp_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   in_valid,
    output logic [1:0]                   in_ready,
    input  logic [1:0]                   in_sign,
    input  logic [2*EXP_BITS-1:0]        in_exp,
    input  logic [2*MANT_W-1:0]          in_sig,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_BITS+SIG_BITS:0]   out_result,
    output logic                         out_src,
    output logic                         out_inexact,
    output logic                         out_overflow
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Producers hold valid and data until ready; valid never waits on ready.

    logic      r_rr_ptr;
    logic      r_s1_valid;
    logic      r_s1_src;
    rnd_req_t  r_s1_req;
    logic      r_s2_valid;
    logic      r_s2_src;
    logic      r_s2_inexact;
    logic      r_s2_overflow;
    fp_word_t  r_s2_word;

    logic              w_s1_adv;
    logic              w_s1_free;
    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_sel;
    rnd_req_t          w_in_req;
    logic [MANT_W-1:0] w_sig_r;
    logic              w_co;
    logic [EXP_BITS-1:0] w_exp_adj;
    fp_word_t          w_word;
    logic              w_inexact;
    logic              w_overflow;

    assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
    assign w_s1_free = !r_s1_valid || w_s1_adv;

    always_comb begin
        w_grant = in_valid;
        if (&in_valid) begin
            w_grant = r_rr_ptr ? 2'b10 : 2'b01;
        end
        in_ready = (w_s1_free && !rst) ? w_grant : 2'b00;
    end

    assign w_accept = |in_ready;
    assign w_sel    = in_ready[1];

    always_comb begin
        w_in_req.sign = in_sign[w_sel];
        w_in_req.exp  = w_sel ? in_exp[EXP_BITS +: EXP_BITS] : in_exp[0 +: EXP_BITS];
        w_in_req.sig  = w_sel ? in_sig[MANT_W +: MANT_W]     : in_sig[0 +: MANT_W];
    end

    rounding u_rounding (
        .i_sig   (r_s1_req.sig),
        .o_sig_r (w_sig_r),
        .o_co    (w_co)
    );

    always_comb begin
        w_exp_adj = r_s1_req.exp;
        if (w_co) begin
            w_exp_adj = r_s1_req.exp + EXP_BITS'(1);
        end else if (r_s1_req.exp == '0 && w_sig_r[MANT_W-1]) begin
            w_exp_adj = EXP_BITS'(1);
        end

        w_word.sign = r_s1_req.sign;
        w_word.exp  = w_exp_adj;
        w_word.frac = w_sig_r[MANT_W-2:3];
        w_inexact   = |r_s1_req.sig[2:0];
        w_overflow  = 1'b0;
        // Inf/NaN operands bypass rounding entirely.
        if (r_s1_req.exp == EXP_MAX) begin
            w_word.exp  = EXP_MAX;
            w_word.frac = r_s1_req.sig[MANT_W-2:3];
            w_inexact   = 1'b0;
        end else if (w_exp_adj == EXP_MAX) begin
            w_word.frac = '0;
            w_overflow  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= 1'b0;
            r_s1_valid    <= 1'b0;
            r_s1_src      <= 1'b0;
            r_s1_req      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_src      <= 1'b0;
            r_s2_inexact  <= 1'b0;
            r_s2_overflow <= 1'b0;
            r_s2_word     <= '0;
        end else begin
            if (w_accept) begin
                r_s1_req <= w_in_req;
                r_s1_src <= w_sel;
                r_rr_ptr <= !w_sel;
            end
            if (w_s1_free) begin
                r_s1_valid <= w_accept;
            end
            // Pop and advance in one cycle overwrite stage 2 without a bubble.
            if (w_s1_adv) begin
                r_s2_valid    <= 1'b1;
                r_s2_src      <= r_s1_src;
                r_s2_word     <= w_word;
                r_s2_inexact  <= w_inexact;
                r_s2_overflow <= w_overflow;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_s2_valid && !rst;
    assign out_result   = rst ? '0   : r_s2_word;
    assign out_src      = rst ? 1'b0 : r_s2_src;
    assign out_inexact  = rst ? 1'b0 : r_s2_inexact;
    assign out_overflow = rst ? 1'b0 : r_s2_overflow;

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Bench for fp_round_arbiter: directed corner cases, arbitration/backpressure/
// reset sequences, then random traffic against an arithmetic reference model.
module tb_fp_round_arbiter;
    import fp_pkg::*;

    localparam int W = 35; // {src, overflow, inexact, result[31:0]}

    logic                       clk = 1'b0;
    logic                       rst;
    logic [1:0]                 drv_valid;
    logic [1:0]                 in_ready;
    logic [1:0]                 op_sign;
    logic [EXP_BITS-1:0]        op_exp [2];
    logic [MANT_W-1:0]          op_sig [2];
    logic [2*EXP_BITS-1:0]      in_exp;
    logic [2*MANT_W-1:0]        in_sig;
    logic                       out_valid;
    logic                       out_ready;
    logic [EXP_BITS+SIG_BITS:0] out_result;
    logic                       out_src;
    logic                       out_inexact;
    logic                       out_overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   acc_seen = 2'b00;
    logic         model_ptr = 1'b0;

    always #5 clk = ~clk;

    assign in_exp = {op_exp[1], op_exp[0]};
    assign in_sig = {op_sig[1], op_sig[0]};

    fp_round_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (drv_valid),
        .in_ready     (in_ready),
        .in_sign      (op_sign),
        .in_exp       (in_exp),
        .in_sig       (in_sig),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_src      (out_src),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: IEEE packing makes (exp, frac) a single integer, so rounding
    // carries propagate into the exponent by plain addition.
    function automatic logic [W-2:0] ref_round(input logic sign, input logic [7:0] e,
                                               input logic [26:0] m);
        int unsigned keep;
        int unsigned rem;
        longint      mag;
        logic        inex;
        if (e == 8'hFF) return {1'b0, 1'b0, sign, 8'hFF, m[25:3]};
        keep = 32'(m >> 3);
        rem  = 32'(m[2:0]);
        inex = (rem != 0);
        if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep++;
        if (e == 0) mag = longint'(keep);
        else        mag = (longint'(e) - 1) * longint'(2**23) + longint'(keep);
        if (mag >= longint'(255) * longint'(2**23)) return {1'b1, inex, sign, 8'hFF, 23'd0};
        return {1'b0, inex, sign, mag[30:0]};
    endfunction

    always @(negedge clk) begin : monitor
        logic [1:0] expg;
        logic       idx;
        if (rst) begin
            exp_q.delete();
            model_ptr = 1'b0;
            acc_seen  = 2'b00;
        end else begin
            acc_seen = drv_valid & in_ready;
            check("ready_without_valid", {62'd0, in_ready & ~drv_valid}, 64'd0);
            if (in_ready != 2'b00) begin
                expg = (&drv_valid) ? (model_ptr ? 2'b10 : 2'b01) : drv_valid;
                check("grant", {62'd0, in_ready}, {62'd0, expg});
            end
            if (acc_seen != 2'b00) begin
                idx = acc_seen[1];
                exp_q.push_back({idx, ref_round(op_sign[idx], op_exp[idx], op_sig[idx])});
                model_ptr = !idx;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_with_nothing_pending", {63'd0, out_valid}, 64'd0);
                end else begin
                    check("result", {29'd0, out_src, out_overflow, out_inexact, out_result},
                          {29'd0, exp_q[0]});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_directed(input string tag, input int port, input logic s,
                                 input logic [7:0] e, input logic [26:0] m,
                                 input logic [31:0] exp_res, input logic exp_inex,
                                 input logic exp_ov);
        bit got;
        @(posedge clk); #1;
        op_sign[port] = s;
        op_exp[port]  = e;
        op_sig[port]  = m;
        drv_valid[port] = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready[port]) got = 1;
        end
        check({tag, "_accept"}, {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        drv_valid[port] = 1'b0;
        @(negedge clk);
        check({tag, "_not_yet_valid"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check({tag, "_valid"},    {63'd0, out_valid},    64'd1);
        check({tag, "_result"},   {32'd0, out_result},   {32'd0, exp_res});
        check({tag, "_src"},      {63'd0, out_src},      64'(port));
        check({tag, "_inexact"},  {63'd0, out_inexact},  {63'd0, exp_inex});
        check({tag, "_overflow"}, {63'd0, out_overflow}, {63'd0, exp_ov});
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic rand_op(output logic s, output logic [7:0] e, output logic [26:0] m);
        s = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       e = 8'h00;
            1:       e = 8'hFE;
            2:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        m = 27'($urandom());
        m[26] = (e != 8'h00);
        if ($urandom_range(0, 3) == 0) m[25:3] = '1;
    endtask

    initial begin : stimulus
        logic [31:0] held_res;
        logic        held_src;
        logic [1:0]  exp_rdy [5];
        logic        srcs [6];
        int          acc;
        int          outs;
        bit          got;

        rst = 1'b1;
        out_ready = 1'b1;
        op_sign = 2'b01;
        op_exp[0] = 8'h7F; op_sig[0] = 27'h4000004;
        op_exp[1] = 8'h80; op_sig[1] = 27'h4000000;
        drv_valid = 2'b11;

        // Reset state with both requesters asking
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   {62'd0, in_ready},     64'd0);
        check("rst_out_valid",  {63'd0, out_valid},    64'd0);
        check("rst_out_result", {32'd0, out_result},   64'd0);
        check("rst_out_src",    {63'd0, out_src},      64'd0);
        check("rst_inexact",    {63'd0, out_inexact},  64'd0);
        check("rst_overflow",   {63'd0, out_overflow}, 64'd0);
        @(posedge clk); #1;
        drv_valid = 2'b00;
        rst = 1'b0;

        send_directed("t1_tie_even",   0, 1'b0, 8'h7F, 27'h4000004, 32'h3F800000, 1'b1, 1'b0);
        send_directed("t2_carry",      1, 1'b0, 8'h7F, 27'h7FFFFFC, 32'h40000000, 1'b1, 1'b0);
        send_directed("t3_overflow",   0, 1'b0, 8'hFE, 27'h7FFFFFC, 32'h7F800000, 1'b1, 1'b1);
        send_directed("t3_passthru",   1, 1'b0, 8'hFF, 27'h4000008, 32'h7F800001, 1'b0, 1'b0);
        send_directed("t4_subnormal",  1, 1'b0, 8'h00, 27'h3FFFFFC, 32'h00800000, 1'b1, 1'b0);

        // Round-robin with both requesters continuously valid
        @(posedge clk); #1;
        op_sign = 2'b10;
        op_exp[0] = 8'h81; op_sig[0] = 27'h4A5A5A5;
        op_exp[1] = 8'h40; op_sig[1] = 27'h7123457;
        out_ready = 1'b1;
        drv_valid = 2'b11;
        acc = 0;
        outs = 0;
        for (int k = 0; k < 40 && outs < 6; k++) begin
            @(negedge clk);
            if ((in_ready & drv_valid) != 2'b00) acc++;
            if (out_valid && out_ready) begin
                srcs[outs] = out_src;
                outs++;
            end
            if (acc == 6 && drv_valid != 2'b00) begin
                @(posedge clk); #1;
                drv_valid = 2'b00;
            end
        end
        check("rr_result_count", 64'(outs), 64'd6);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("rr_src_%0d", j), {63'd0, srcs[j]}, 64'(j % 2));
        end

        // Backpressure: both stages fill, then grants stop
        @(posedge clk); #1;
        out_ready = 1'b0;
        drv_valid = 2'b11;
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10;
        exp_rdy[2] = 2'b00; exp_rdy[3] = 2'b00; exp_rdy[4] = 2'b00;
        held_res = '0;
        held_src = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready_%0d", k), {62'd0, in_ready}, {62'd0, exp_rdy[k]});
            if (k == 2) begin
                held_res = out_result;
                held_src = out_src;
            end else if (k > 2) begin
                check($sformatf("stall_valid_%0d", k),  {63'd0, out_valid},  64'd1);
                check($sformatf("stall_result_%0d", k), {32'd0, out_result}, {32'd0, held_res});
                check($sformatf("stall_src_%0d", k),    {63'd0, out_src},    {63'd0, held_src});
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_grant", {62'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        drv_valid = 2'b00;
        drain("stall");

        // Reset with both stages full discards in-flight results
        @(posedge clk); #1;
        out_ready = 1'b0;
        drv_valid = 2'b11;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready == 2'b00 && out_valid) got = 1;
        end
        check("full_before_reset", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {62'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_grant",     {62'd0, in_ready},  64'd1);
        @(posedge clk); #1;
        drv_valid = 2'b00;
        drain("post_reset");

        // Random traffic with random consumer stalls
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (acc_seen[i] || !drv_valid[i]) begin
                    rand_op(op_sign[i], op_exp[i], op_sig[i]);
                    drv_valid[i] = ($urandom_range(0, 3) != 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        drv_valid = 2'b00;
        out_ready = 1'b1;
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
